// File: rtl/video_timing_pattern_gen.sv
// Purpose: raster timing (DE/HS/VS) plus built-in test-pattern source for the DVI output path.
// Latency: every output is registered, exactly 1 cycle from counter state; all outputs mutually aligned.
// Backpressure: none; downstream samples every cycle. EN=0 or reset idles the raster on the next edge.
//
// Ports:
//   CLK          pixel clock (only clock)
//   RST_N        synchronous reset, active low
//   EN           1 = run raster, 0 = hold counters at 0 with idle outputs
//   PATTERN      0 bars, 1 grey ramp, 2 checkerboard, 3 solid blue (taken at frame origin)
//   DE/HS/VS     data enable and syncs (sync polarity from HS_POL/VS_POL)
//   R/G/B        8-bit colour, zero outside the active region
//   X/Y          active column/line, zero outside the active region
//   FRAME_START  one-cycle pulse on the first active pixel of a frame
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [1:0]  PATTERN,
    output logic        DE,
    output logic        HS,
    output logic        VS,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic [11:0] X,
    output logic [11:0] Y,
    output logic        FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_LO = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_HI = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_LO = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_HI = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] BAR_LAST  = 12'(BAR_W - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] bar_px;    // pixel position inside the current colour bar
    logic [2:0]  bar_idx;   // which of the 8 bars h_cnt is in
    logic [1:0]  pat_q;

    logic        frame_origin;
    logic [1:0]  pat_sel;
    logic        active;
    logic        hs_on;
    logic        vs_on;
    logic [23:0] pix_rgb;

    assign frame_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    // The first pixel of a frame already uses the pattern being latched on this edge,
    // so the whole frame shows a single pattern.
    assign pat_sel = frame_origin ? PATTERN : pat_q;
    assign active  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_on   = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
    assign vs_on   = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);

    always_comb begin
        pix_rgb = 24'h000000;
        case (pat_sel)
            2'd0: begin
                case (bar_idx)
                    3'd0:    pix_rgb = 24'hFFFFFF;
                    3'd1:    pix_rgb = 24'hFFFF00;
                    3'd2:    pix_rgb = 24'h00FFFF;
                    3'd3:    pix_rgb = 24'h00FF00;
                    3'd4:    pix_rgb = 24'hFF00FF;
                    3'd5:    pix_rgb = 24'hFF0000;
                    3'd6:    pix_rgb = 24'h0000FF;
                    default: pix_rgb = 24'h000000;
                endcase
            end
            2'd1:    pix_rgb = {h_cnt[7:0], h_cnt[7:0], h_cnt[7:0]};
            2'd2:    pix_rgb = (h_cnt[4] ^ v_cnt[4]) ? 24'h000000 : 24'hFFFFFF;
            default: pix_rgb = 24'h0000FF;
        endcase
    end

    // Raster counters, bar tracker and pattern latch.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            h_cnt   <= 12'd0;
            v_cnt   <= 12'd0;
            bar_px  <= 12'd0;
            bar_idx <= 3'd0;
            pat_q   <= 2'd0;
        end else if (!EN) begin
            h_cnt   <= 12'd0;
            v_cnt   <= 12'd0;
            bar_px  <= 12'd0;
            bar_idx <= 3'd0;
        end else begin
            if (frame_origin) begin
                pat_q <= PATTERN;
            end
            if (h_cnt == H_LAST) begin
                h_cnt   <= 12'd0;
                bar_px  <= 12'd0;
                bar_idx <= 3'd0;
                v_cnt   <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
                // Bars advance by counting pixels; no divide by the bar width.
                if (h_cnt < H_ACT_C) begin
                    if (bar_px == BAR_LAST) begin
                        bar_px  <= 12'd0;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_px <= bar_px + 12'd1;
                    end
                end
            end
        end
    end

    // Output register stage.
    always_ff @(posedge CLK) begin
        if (!RST_N || !EN) begin
            DE          <= 1'b0;
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            R           <= 8'd0;
            G           <= 8'd0;
            B           <= 8'd0;
            X           <= 12'd0;
            Y           <= 12'd0;
            FRAME_START <= 1'b0;
        end else begin
            DE          <= active;
            HS          <= hs_on ? HS_POL : ~HS_POL;
            VS          <= vs_on ? VS_POL : ~VS_POL;
            R           <= active ? pix_rgb[23:16] : 8'd0;
            G           <= active ? pix_rgb[15:8]  : 8'd0;
            B           <= active ? pix_rgb[7:0]   : 8'd0;
            X           <= active ? h_cnt : 12'd0;
            Y           <= active ? v_cnt : 12'd0;
            FRAME_START <= active && frame_origin;
        end
    end

endmodule
